// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM
// encoding and the done-flag blanking window.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MFHI = 2'b10;
    localparam logic [1:0] OP_MFLO = 2'b11;

    // Cycles at the start of a run during which the unit's done flag is
    // still the stale value from the previous operation.
    localparam int DONE_BLANK = 2;

    localparam int RUN_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN_MULT = 2'd1,
        ST_RUN_DIV  = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    function automatic logic is_run(input state_t s);
        return (s == ST_RUN_MULT) || (s == ST_RUN_DIV);
    endfunction

endpackage

// File: rtl/run_watchdog.sv
// Cycle counter for a RUN state, with a terminal-count flag that marks the
// last cycle before the sequencer gives up on the unit.
module run_watchdog #(
    parameter int TIMEOUT_CYCLES = 48,
    parameter int CNT_W          = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] run_cnt,
    output logic             tc
);

    // Counter restarts from 0 whenever the sequencer is outside a RUN state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (clear) begin
            run_cnt <= '0;
        end else if (enable) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign tc = (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer between the control unit and the iterative multiplier/divider.
// Handshake: an op is taken on a rising clock edge where op_valid && op_ready;
// op_ready is high only in IDLE, and op_code/op_b are sampled only on that
// edge. The unit ctrl lines are level start/hold signals; done is sticky and
// only cleared by the unit's own init cycle, hence the blanking window.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] op_b,
    output logic        op_ready,
    output logic        busy,
    output logic        mult_ctrl,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        div_ctrl,
    input  logic        div_done,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        div_zero,
    output logic        timeout_err,
    output state_t      dbg_state
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;
    logic                   in_run;
    logic [RUN_CNT_W-1:0]   run_cnt;
    logic                   run_tc;
    logic                   unit_done;
    logic                   done_valid;
    logic [31:0]            res_hi;
    logic [31:0]            res_lo;

    assign accept     = op_valid && (state == ST_IDLE);
    assign in_run     = is_run(state);
    assign unit_done  = (state == ST_RUN_MULT) ? mult_done : div_done;
    assign done_valid = in_run && unit_done && (run_cnt >= RUN_CNT_W'(DONE_BLANK));
    assign res_hi     = (state == ST_RUN_MULT) ? mult_hi : div_hi;
    assign res_lo     = (state == ST_RUN_MULT) ? mult_lo : div_lo;
    assign dbg_state  = state;

    run_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (RUN_CNT_W)
    ) u_run_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (!in_run),
        .enable  (in_run),
        .run_cnt (run_cnt),
        .tc      (run_tc)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a valid done wins over the watchdog on the same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op_code == OP_MULT) begin
                        state_nxt = ST_RUN_MULT;
                    end else if ((op_code == OP_DIV) && (op_b != 32'd0)) begin
                        state_nxt = ST_RUN_DIV;
                    end
                end
            end
            ST_RUN_MULT, ST_RUN_DIV: begin
                if (done_valid || run_tc) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only, so ctrl drops as soon as reset does.
    always_comb begin
        op_ready  = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        mult_ctrl = (state == ST_RUN_MULT);
        div_ctrl  = (state == ST_RUN_DIV);
    end

    // HI/LO commit, MFHI/MFLO read-out and the one-cycle event pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi          <= 32'd0;
            lo          <= 32'd0;
            rd_data     <= 32'd0;
            rd_valid    <= 1'b0;
            div_zero    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rd_valid    <= 1'b0;
            div_zero    <= 1'b0;
            timeout_err <= 1'b0;
            if (accept) begin
                case (op_code)
                    OP_MFHI: begin
                        rd_data  <= hi;
                        rd_valid <= 1'b1;
                    end
                    OP_MFLO: begin
                        rd_data  <= lo;
                        rd_valid <= 1'b1;
                    end
                    OP_DIV: begin
                        if (op_b == 32'd0) begin
                            div_zero <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (done_valid) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (in_run && run_tc) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer that sits between the main control unit and the iterative multiplier/divider datapaths. It accepts MULT/DIV/MFHI/MFLO operations, drives the level-sensitive start input of the selected unit, and waits for that unit's done flag. It then commits the result into the architectural HI/LO registers and returns the unit to its initialise state. It also provides the stall (`busy`) signal, a divide-by-zero trap, and a watchdog against a unit that never finishes.

## Interface
- `TIMEOUT_CYCLES`, default 48: maximum cycles spent in a RUN state before abort.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `op_valid`  in  1  operation request from control unit.
- `op_code`  in  2  00 MULT, 01 DIV, 10 MFHI, 11 MFLO.
- `op_b`  in  32  divisor operand (same value driven to the divider), used for the zero check.
- `op_ready`  out  1  high only in IDLE; an op is accepted on a clock edge with `op_valid && op_ready`.
- `busy`  out  1  high in RUN_MULT, RUN_DIV and DRAIN; control unit stalls on it.
- `mult_ctrl`  out  1  level start/hold to multiplier.
- `mult_done`  in  1  multiplier done flag. It is sticky and only cleared by the unit's own init cycle.
- `mult_hi`, `mult_lo`  in  32 each  multiplier result.
- `div_ctrl`  out  1  level start/hold to divider.
- `div_done`  in  1  divider done flag; sticky, same semantics as `mult_done`.
- `div_hi`, `div_lo`  in  32 each  remainder / quotient.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.
- `rd_data`  out  32  MFHI/MFLO result.
- `rd_valid`  out  1  one-cycle pulse qualifying `rd_data`.
- `div_zero`  out  1  one-cycle pulse: DIV rejected, divisor zero.
- `timeout_err`  out  1  one-cycle pulse: watchdog abort.

## Operation
- States: IDLE, RUN_MULT, RUN_DIV, DRAIN.
- IDLE:
  - MULT accepted → RUN_MULT.
  - DIV accepted with `op_b != 0` → RUN_DIV.
  - DIV accepted with `op_b == 0` → stay IDLE, pulse `div_zero`, HI/LO unchanged, no ctrl asserted.
  - MFHI/MFLO accepted → stay IDLE; `rd_data` = `hi`/`lo` and `rd_valid` = 1 on the next cycle.
- RUN_x:
  - `x_ctrl` = 1, and a 7-bit `run_cnt` increments each cycle starting from 0.
  - `x_done` is ignored while `run_cnt < 2`, because the unit's stale done flag is still visible before its init cycle completes.
  - On an edge where `x_done` = 1 and `run_cnt >= 2`: `hi` ← `x_hi`, `lo` ← `x_lo`, state → DRAIN.
  - If `run_cnt == TIMEOUT_CYCLES-1` with no valid done: state → DRAIN, `timeout_err` pulses, HI/LO unchanged.
- DRAIN: all ctrl outputs 0 for exactly one cycle so the unit re-arms its init flag; then → IDLE.
- Only one ctrl line is ever high. `mult_ctrl` and `div_ctrl` are never both 1.
- `op_code` and `op_b` are sampled only at acceptance. Changes while `busy` is high have no effect.

## Timing
- Reset values: state IDLE; `hi` = `lo` = `rd_data` = 0; `run_cnt` = 0; `op_ready` = 1; `busy`, `mult_ctrl`, `div_ctrl`, `rd_valid`, `div_zero`, `timeout_err` = 0.
- Reset asserted mid-RUN: ctrl lines drop immediately (asynchronous); HI/LO are cleared.
- Accept at edge t:
  - `mult_ctrl`/`div_ctrl` high from t+1.
  - With the 32-iteration multiplier, `mult_done` is first seen at t+34. HI/LO update at that edge, DRAIN runs at t+35, and `op_ready` returns at t+36.
- `rd_valid`, `div_zero` and `timeout_err` are registered one-cycle pulses, asserted in the cycle after the causing edge.
- Back-to-back MFHI/MFLO: one accepted per cycle, each producing one `rd_valid`.
- MFHI accepted in the same cycle that DRAIN exits: not possible, because `op_ready` = 0 in DRAIN.

## Structure
- Package `muldiv_pkg`:
  - op_code localparams `OP_MULT`, `OP_DIV`, `OP_MFHI`, `OP_MFLO`.
  - state encoding (2 bits).
  - `DONE_BLANK` = 2.
- One natural sub-module, `run_watchdog`: the `run_cnt` counter with clear/enable and a terminal-count flag at `TIMEOUT_CYCLES-1`.
- Result muxing, HI/LO registers and the FSM stay in the top module.

## Test plan
- Reset, then MULT with multiplier model A=7, B=−3 → `mult_ctrl` high for 34 cycles; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `op_ready` back 2 cycles after done.
- MULT with stale `mult_done`=1 held from the previous op → no commit during the first 2 RUN cycles; the commit uses the new result.
- DIV with `op_b`=0 → `div_zero` pulse, `div_ctrl` never rises, HI/LO unchanged, `op_ready` stays 1.
- DIV 100/7 with a divider model → `hi`=2, `lo`=14; then MFHI, MFLO back-to-back → `rd_data` 2 then 14, each with `rd_valid`.
- Unit model never raises done, `TIMEOUT_CYCLES`=48 → `timeout_err` pulse after 48 RUN cycles, HI/LO unchanged, IDLE 2 cycles later.
- Assert `reset` 10 cycles into RUN_DIV → `div_ctrl` falls asynchronously, all outputs at reset values; a fresh MULT afterwards completes correctly.
